// File: rtl/operand_sel_reg.sv
// Registered N:1 operand selector with direct-select and round-robin modes.
// A valid/ready handshake loads one holding register per cycle; an unselectable channel yields a zero operand.
module operand_sel_reg #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    err_sel,
    input  logic                    clr_err
);

    localparam int SLOTS = 2**SEL_W;
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

    logic [WIDTH-1:0] ch_data [SLOTS];
    logic [SLOTS-1:0] valid_pad;

    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;
    logic [SEL_W-1:0] ch_p1;
    logic             err_p1;
    logic [SEL_W-1:0] rr_ptr;

    logic             load_en;
    logic             sel_ok;
    logic             grant_ok;
    logic             take;
    logic             drop;
    logic             set_err;
    logic [SEL_W-1:0] pick;
    logic             rr_hit;
    logic [SEL_W-1:0] rr_grant;
    logic [SEL_W-1:0] rr_next;
    logic [SEL_W:0]   idx;
    logic [SEL_W:0]   nxt;

    // Slots beyond NUM_CH read as invalid zero operands, so every select index is in range
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        if (k < NUM_CH) begin : g_live
            assign ch_data[k]   = in_data[k*WIDTH +: WIDTH];
            assign valid_pad[k] = in_valid[k];
        end else begin : g_pad
            assign ch_data[k]   = '0;
            assign valid_pad[k] = 1'b0;
        end
    end

    always_comb begin
        rr_hit   = 1'b0;
        rr_grant = '0;
        idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_ptr} + (SEL_W+1)'(i);
            if (idx >= NUM_CH_W) idx = idx - NUM_CH_W;
            if (!rr_hit && valid_pad[idx[SEL_W-1:0]]) begin
                rr_hit   = 1'b1;
                rr_grant = idx[SEL_W-1:0];
            end
        end
        nxt = {1'b0, rr_grant} + (SEL_W+1)'(1);
        if (nxt == NUM_CH_W) nxt = '0;
        rr_next = nxt[SEL_W-1:0];
    end

    always_comb begin
        load_en  = !vld_p1 || out_ready;
        sel_ok   = ({1'b0, sel} < NUM_CH_W);
        take     = 1'b0;
        drop     = 1'b0;
        set_err  = 1'b0;
        grant_ok = 1'b0;
        pick     = sel;
        if (!mode) begin
            if (sel_ok) begin
                grant_ok = load_en && valid_pad[sel];
                take     = grant_ok;
                drop     = load_en && !valid_pad[sel];
            end else begin
                take    = load_en;
                set_err = load_en;
            end
        end else begin
            pick     = rr_grant;
            grant_ok = load_en && rr_hit;
            take     = grant_ok;
            drop     = load_en && !rr_hit;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            in_ready[k] = reset_n && grant_ok && (pick == SEL_W'(k));
    end

    // Stage p1: output holding register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            ch_p1   <= '0;
            err_p1  <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            if (take) begin
                data_p1 <= ch_data[pick];
                ch_p1   <= pick;
                vld_p1  <= 1'b1;
            end else if (drop) begin
                vld_p1  <= 1'b0;
            end
            if (take && mode) rr_ptr <= rr_next;
            if (set_err)      err_p1 <= 1'b1;
            else if (clr_err) err_p1 <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign out_ch    = ch_p1;
    assign err_sel   = err_p1;

endmodule
